// File: rtl/layer1_maxpool2x2.sv
// layer1_maxpool2x2
// Lane-wise ReLU followed by 2x2 stride-2 max pooling over the raster-ordered
// output stream of the layer-1 convolution. A one-word horizontal hold
// register pairs even/odd columns; a half-width line buffer carries the
// pooled pair of each even row down to the odd row that completes the window.
// Inputs that arrive out of raster order, out of range, or after the frame
// has finished are discarded and flagged on a sticky error output.

module layer1_maxpool2x2 #(
  parameter int IN_DIM = 30,
  parameter int LANES  = 8,
  parameter int DW     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [15:0]           in_row,
  input  logic [15:0]           in_col,
  input  logic [LANES*DW-1:0]   in_data,
  output logic                  out_valid,
  output logic [15:0]           out_row,
  output logic [15:0]           out_col,
  output logic [LANES*DW-1:0]   out_data,
  output logic                  pool_done,
  output logic                  order_err
);

  localparam int HALF = IN_DIM / 2;
  localparam int WW   = LANES * DW;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [15:0] DIM_W      = 16'(IN_DIM);
  localparam logic [15:0] LAST_IDX   = 16'(IN_DIM - 1);
  localparam logic [15:0] LAST_POOL  = 16'(HALF - 1);

  typedef logic [WW-1:0] word_t;

  // Per-lane ReLU: a set sign bit clips the lane to zero.
  function automatic word_t relu(input word_t v);
    word_t r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      r[k*DW +: DW] = v[k*DW + DW - 1] ? '0 : v[k*DW +: DW];
    end
    return r;
  endfunction

  // Per-lane unsigned maximum; only meaningful on post-ReLU (non-negative) data.
  function automatic word_t lane_max(input word_t a, input word_t b);
    word_t r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      r[k*DW +: DW] = (a[k*DW +: DW] > b[k*DW +: DW]) ? a[k*DW +: DW] : b[k*DW +: DW];
    end
    return r;
  endfunction

  // Expected raster position of the next sample.
  logic [15:0] exp_row;
  logic [15:0] exp_col;

  // Rectified even-column sample waiting for its odd-column partner.
  word_t hold_reg;

  // Pooled horizontal pairs of the most recent even row, one per output column.
  word_t linebuf [HALF];

  logic          in_range;
  logic          in_pos_ok;
  logic          accept;
  logic          col_last;
  logic          pair_wr;
  logic          win_done;
  logic [AW-1:0] lb_idx;
  word_t         relu_in;
  word_t         pair_max;
  word_t         win_max;

  // Acceptance, parity decode and the window-max datapath.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    in_range  = 1'b0;
    in_pos_ok = 1'b0;
    accept    = 1'b0;
    col_last  = 1'b0;
    pair_wr   = 1'b0;
    win_done  = 1'b0;
    lb_idx    = '0;
    relu_in   = '0;
    pair_max  = '0;
    win_max   = '0;

    in_range  = (in_row < DIM_W) && (in_col < DIM_W);
    in_pos_ok = (in_row == exp_row) && (in_col == exp_col);
    accept    = in_valid && !pool_done && in_range && in_pos_ok;
    col_last  = (exp_col == LAST_IDX);

    // Only the accepted path uses lb_idx, so it is always in range there.
    lb_idx    = in_col[AW:1];
    relu_in   = relu(in_data);
    pair_max  = lane_max(hold_reg, relu_in);
    win_max   = lane_max(linebuf[lb_idx], pair_max);

    pair_wr   = accept && !in_row[0] &&  in_col[0];
    win_done  = accept &&  in_row[0] &&  in_col[0];
  end

  // Raster position tracker; advances only on accepted samples.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      exp_row <= '0;
      exp_col <= '0;
    end else if (accept) begin
      if (col_last) begin
        exp_col <= '0;
        exp_row <= exp_row + 16'd1;
      end else begin
        exp_col <= exp_col + 16'd1;
      end
    end
  end

  // Horizontal hold: capture the rectified even-column sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= '0;
    end else if (accept && !in_col[0]) begin
      hold_reg <= relu_in;
    end
  end

  // Line buffer: even rows store their horizontal pair maxima.
  always_ff @(posedge clk) begin
    // NOTE: the line buffer is cleared on reset so a restarted frame can never
    // observe pairs left over from an aborted one; this keeps it in flops.
    if (rst) begin
      for (int i = 0; i < HALF; i++) begin
        linebuf[i] <= '0;
      end
    end else if (pair_wr) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

  // Output register: one-cycle pulse per completed window, fields hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= win_done;
      if (win_done) begin
        out_row  <= in_row >> 1;
        out_col  <= in_col >> 1;
        out_data <= win_max;
      end
    end
  end

  // Sticky status: frame completion and dropped-sample detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      pool_done <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (out_valid && (out_row == LAST_POOL) && (out_col == LAST_POOL)) begin
        pool_done <= 1'b1;
      end
      if (in_valid && !accept) begin
        order_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/layer1_maxpool2x2.md
Name: layer1_maxpool2x2

Overview:
- Downstream of the layer-1 convolution stage; consumes its per-pixel result stream (save-enable, row, col, 128-bit data).
- Applies lane-wise ReLU, then 2x2 stride-2 max pooling, to the 30x30x8 feature map.
- Emits a 15x15x8 pooled stream with the same valid/row/col/data format, ready for layer 2 or the result memory.

Parameters:
- IN_DIM, 30, input feature-map height/width; must be even.
- LANES, 8, channels packed per input word.
- DW, 16, bits per lane, two's complement.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  input sample present this cycle (conv save_enable)
- in_row  input  16  input row, 0..IN_DIM-1
- in_col  input  16  input column, 0..IN_DIM-1
- in_data  input  LANES*DW  lane k at bits [k*DW +: DW]
- out_valid  output  1  pooled sample present
- out_row  output  16  pooled row, 0..IN_DIM/2-1
- out_col  output  16  pooled column, 0..IN_DIM/2-1
- out_data  output  LANES*DW  pooled lanes, same packing
- pool_done  output  1  sticky: full frame pooled
- order_err  output  1  sticky: out-of-order or out-of-range input seen

Behaviour:
- Reset: rst synchronous, active-high; clock clk. On reset all outputs are 0, expected-position counters are (0,0), horizontal hold register is 0, line buffer is cleared.
- Input order: strict raster (row-major). Gaps (in_valid=0) are allowed anywhere and have no effect.
- Internal counters exp_row/exp_col advance by 1 per accepted sample. exp_col wraps IN_DIM-1 -> 0 and increments exp_row.
- Order check: an in_valid sample with (in_row,in_col) != (exp_row,exp_col), or with either index >= IN_DIM, is dropped. The drop sets order_err; counters and datapath are unchanged.
- ReLU, per lane: a negative value (MSB=1) becomes 0, otherwise unchanged. After ReLU all compares are unsigned DW-bit.
- Datapath by input position parity:
  - even col: hold_reg <= relu(in).
  - even row, odd col: linebuf[in_col>>1] <= lanewise max(hold_reg, relu(in)).
  - odd row, odd col: window max = lanewise max(linebuf[in_col>>1], hold_reg, relu(in)).
- Line buffer: IN_DIM/2 entries of LANES*DW bits, one write port, one read port.
- Output registering: on the cycle after an accepted odd-row/odd-col sample:
  - out_valid=1, out_row=in_row>>1, out_col=in_col>>1, out_data=window max.
  - Otherwise out_valid=0; out_row/out_col/out_data hold their last values.
- Latency: exactly 1 cycle from the completing input to out_valid. Throughput is one input per cycle, no backpressure.
- Completion: when the pooled output (IN_DIM/2-1, IN_DIM/2-1) is emitted, pool_done rises the following cycle and stays high until rst.
  - After pool_done, further in_valid samples are dropped and set order_err.
- Simultaneous events: rst overrides everything, including an in_valid sample in the same cycle.
- Reset mid-frame discards partial windows; the next frame restarts at (0,0).
- Width: no arithmetic growth; max of DW-bit values is DW bits. Row/col outputs are zero-extended to 16 bits.

Test Plan:
- Reset check: assert rst 2 cycles -> out_valid=0, out_data=0, pool_done=0, order_err=0.
- Single window: feed (0,0)..(0,29) then (1,0)..(1,1) with lane0 values 5,9 (row 0) and 3,7 (row 1), all other lanes 0. -> One cycle after (1,1): out_valid=1, out_row=0, out_col=0, lane0=9.
- ReLU: a window with lane3 = -100,-1,-32768,-5 -> output lane3=0. A lane mixing 0x8000 and 0x0001 -> output 1 (negatives clipped, not treated as large).
- Full frame: random 30x30 raster with random in_valid gaps. -> Exactly 225 out_valid pulses in raster order, matching a reference model. pool_done=1 the cycle after output (14,14); order_err=0.
- Order error: send (0,0) then (0,2). -> order_err=1, the (0,2) sample is ignored. Sending (0,1) next is accepted and the frame continues correctly.
- Mid-frame reset: reset after input (10,17), then a fresh full frame. -> 225 correct outputs, no stale line-buffer data, pool_done set once.
